core_wb_arb: RTL and testbench
==============================

// Module: core_wb_arb
// PURPOSE
//  Two-master Wishbone arbiter between core bus masters and the external bus.
//  Master 0 is instruction fetch; master 1 is the memory access unit (loads/stores).
//  Grants one master at a time and muxes its cycle onto the slave port.
//  Includes a bus watchdog that errors out unanswered strobes.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width (SEL width = DW/8)
//  TIMEOUT  255 cycles of unanswered stb_o before forced error (1..2^TO_W-1)
//  TO_W     8   watchdog counter width
// PORTS
//  clk        in   1      core clock
//  rst        in   1      synchronous active-high reset
//  m0_adr_i   in   AW     fetch address
//  m0_dat_i   in   DW     fetch write data (unused by fetch, routed anyway)
//  m0_sel_i   in   DW/8   byte selects
//  m0_we_i    in   1      write enable
//  m0_cyc_i   in   1      cycle request / bus hold
//  m0_stb_i   in   1      strobe
//  m0_dat_o   out  DW     read data (broadcast of dat_i)
//  m0_ack_o   out  1      ack, only when m0 granted
//  m0_err_o   out  1      err (slave err_i or watchdog), only when m0 granted
//  m0_rty_o   out  1      retry, only when m0 granted
//  m1_*       --   --     identical set for the memory access unit
//  adr_o      out  AW     slave address
//  dat_o      out  DW     slave write data
//  dat_i      in   DW     slave read data
//  sel_o      out  DW/8   slave byte selects
//  we_o/cyc_o/stb_o out 1 slave control
//  ack_i/err_i/rty_i in 1 slave termination
//  gnt_o      out  2      one-hot current grant {m1,m0}; 00 = none
//  timeout_o  out  1      one-cycle pulse when watchdog fires
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE, gnt_o=00, last=m0, wdog=0; all slave
//   outputs 0, all m*_ack/err/rty 0, timeout_o 0. Reset mid-cycle drops the bus.
//  States: IDLE, GNT0, GNT1, ABORT.
//  IDLE: no master on bus. Next edge: only m1_cyc -> GNT1; only m0_cyc -> GNT0;
//   both -> grant the master != last (first contention after reset goes to m1).
//   Grant latency 1 cycle from cyc request seen in IDLE.
//  GNTx: cyc_o=mx_cyc_i, stb_o=mx_stb_i, adr/dat/sel/we from mx (combinational).
//   mx_ack_o=ack_i, mx_err_o=err_i|wdog_fire, mx_rty_o=rty_i; other master's
//   terminations held 0. mx_dat_o = m(other)_dat_o = dat_i always.
//   Grant held while mx_cyc_i=1 (locked across multiple stb beats).
//   mx_cyc_i=0 -> IDLE, last=x. Mandatory 1 idle cycle (cyc_o=0) between owners.
//  Outside GNTx: adr_o,dat_o,sel_o,we_o,cyc_o,stb_o all 0.
//  Watchdog: wdog counts cycles with stb_o=1 and no ack_i/err_i/rty_i; cleared
//   on any termination, on stb_o=0, on leaving GNTx. Saturates, never wraps.
//   When wdog==TIMEOUT-1 and still no termination: wdog_fire this cycle ->
//   mx_err_o=1, timeout_o=1, next state ABORT.
//  ABORT: cyc_o=stb_o=0, no terminations forwarded; stays until granted
//   master drops cyc, then IDLE with last=x.
//  Simultaneous ack_i and wdog_fire: ack wins, no error, no timeout_o.
//  Terminations arriving with stb_o=0 are ignored (not forwarded).
// TESTING
//  rst, m0_cyc/stb=1 adr=0x100 -> gnt_o=01 next cycle; adr_o=0x100; ack_i=1
//   -> m0_ack_o=1, m1_ack_o=0; m0 drops cyc -> one cycle cyc_o=0.
//  After reset, m0 and m1 raise cyc same cycle -> m1 granted first; on release,
//   m0 granted after one idle cycle; repeated contention alternates.
//  m1 holds cyc over 3 stb beats while m0 requests -> gnt stays 10 throughout.
//  TIMEOUT=4, stb held, no termination -> m_err_o and timeout_o on 4th stb
//   cycle; cyc_o=0 next cycle; stays ABORT until master drops cyc.
//  ack_i in same cycle watchdog would fire -> ack forwarded, timeout_o=0.
//  rst asserted mid GNT1 beat -> next cycle gnt_o=00, cyc_o=0, all acks 0.

Source files
------------

// File: rtl/core_wb_arb.sv
// rtl/core_wb_arb.sv - two-master Wishbone arbiter with bus watchdog
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   m0_* / m1_*         master ports (m0 = instruction fetch, m1 = load/store unit):
//                       adr/dat/sel/we/cyc/stb in, dat/ack/err/rty out
//   adr_o..stb_o        slave request side, driven only while a master is granted
//   dat_i, ack_i,
//   err_i, rty_i        slave response side
//   gnt_o               one-hot current grant {m1,m0}, 00 when no master owns the bus
//   timeout_o           one-cycle pulse when the watchdog aborts a strobe
module core_wb_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    input  logic [DW-1:0]   dat_i,
    output logic [DW/8-1:0] sel_o,
    output logic            we_o,
    output logic            cyc_o,
    output logic            stb_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            rty_i,
    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] WDOG_MAX  = '1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t          state, state_nxt;
    logic            last, last_nxt;      // 1 = m1 owned the bus most recently
    logic [TO_W-1:0] wdog, wdog_nxt;
    logic            granted, sel_m1, cur_cyc, term, wdog_fire;
    logic            fwd_ack, fwd_err, fwd_rty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b0;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        wdog_nxt  = '0;
        adr_o     = '0;
        dat_o     = '0;
        sel_o     = '0;
        we_o      = 1'b0;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        gnt_o     = 2'b00;
        m0_dat_o  = dat_i;
        m1_dat_o  = dat_i;

        granted = (state == GNT0) || (state == GNT1);
        sel_m1  = (state == GNT1);
        cur_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;

        if (granted) begin
            gnt_o = sel_m1 ? 2'b10 : 2'b01;
            cyc_o = cur_cyc;
            stb_o = sel_m1 ? m1_stb_i : m0_stb_i;
            adr_o = sel_m1 ? m1_adr_i : m0_adr_i;
            dat_o = sel_m1 ? m1_dat_i : m0_dat_i;
            sel_o = sel_m1 ? m1_sel_i : m0_sel_i;
            we_o  = sel_m1 ? m1_we_i  : m0_we_i;
        end

        // Terminations count only against a live strobe; any real termination
        // pre-empts the watchdog, so an ack on the last cycle still succeeds.
        term      = ack_i | err_i | rty_i;
        wdog_fire = stb_o && !term && (wdog == WDOG_LAST);
        fwd_ack   = stb_o & ack_i;
        fwd_err   = (stb_o & err_i) | wdog_fire;
        fwd_rty   = stb_o & rty_i;
        timeout_o = wdog_fire;

        m0_ack_o = fwd_ack & (state == GNT0);
        m0_err_o = fwd_err & (state == GNT0);
        m0_rty_o = fwd_rty & (state == GNT0);
        m1_ack_o = fwd_ack & sel_m1;
        m1_err_o = fwd_err & sel_m1;
        m1_rty_o = fwd_rty & sel_m1;

        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
                else if (m1_cyc_i)        state_nxt = GNT1;
                else if (m0_cyc_i)        state_nxt = GNT0;
            end
            GNT0, GNT1: begin
                // last also records the aborted owner, so ABORT knows whose cyc to watch
                if (wdog_fire) begin
                    state_nxt = ABORT;
                    last_nxt  = sel_m1;
                end else if (!cur_cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = sel_m1;
                end
            end
            ABORT: begin
                if (!(last ? m1_cyc_i : m0_cyc_i)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (granted && (state_nxt == state) && stb_o && !term)
            wdog_nxt = (wdog == WDOG_MAX) ? wdog : wdog + 1'b1;
    end

endmodule

// File: tb/tb_core_wb_arb.sv
// tb/tb_core_wb_arb.sv - self-checking bench for core_wb_arb
module tb_core_wb_arb;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i, sel_o;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        we_o, cyc_o, stb_o, ack_i, err_i, rty_i, timeout_o;
    logic [1:0]  gnt_o;

    int errors = 0;
    int checks = 0;

    core_wb_arb #(.AW(32), .DW(32), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        dat_i = '0; ack_i = 0; err_i = 0; rty_i = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({gnt_o, cyc_o, stb_o, we_o, timeout_o} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", {gnt_o, cyc_o, stb_o, we_o, timeout_o});
        end
        checks++;
        if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o, adr_o} !== 38'b0) begin
            errors++; $display("FAIL reset_terms: got %h want 0", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o, adr_o});
        end
    endtask

    task automatic test_single_m0;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100; dat_i = 32'hCAFE_0001;
        #1;
        checks++;
        if (gnt_o !== 2'b00) begin errors++; $display("FAIL single_latency: gnt=%b want 00", gnt_o); end
        tick();
        checks++;
        if (gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt: gnt=%b want 01", gnt_o); end
        checks++;
        if (adr_o !== 32'h100 || cyc_o !== 1'b1) begin
            errors++; $display("FAIL single_adr: adr=%h cyc=%b want 100 1", adr_o, cyc_o);
        end
        ack_i = 1;
        #1;
        checks++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10 || m0_dat_o !== 32'hCAFE_0001 || m1_dat_o !== 32'hCAFE_0001) begin
            errors++; $display("FAIL single_ack: m0/m1 ack=%b%b dat=%h want 10 cafe0001", m0_ack_o, m1_ack_o, m0_dat_o);
        end
        tick();
        ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        checks++;
        if (cyc_o !== 1'b0 || gnt_o !== 2'b00) begin
            errors++; $display("FAIL single_release: cyc=%b gnt=%b want 0 00", cyc_o, gnt_o);
        end
    endtask

    task automatic test_contention;
        do_reset();
        m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        checks++;
        if (gnt_o !== 2'b10) begin errors++; $display("FAIL contend_first: gnt=%b want 10", gnt_o); end
        m1_cyc_i = 0;
        tick();
        checks++;
        if (gnt_o !== 2'b00 || cyc_o !== 1'b0) begin
            errors++; $display("FAIL contend_gap: gnt=%b cyc=%b want 00 0", gnt_o, cyc_o);
        end
        tick();
        checks++;
        if (gnt_o !== 2'b01) begin errors++; $display("FAIL contend_second: gnt=%b want 01", gnt_o); end
        m1_cyc_i = 1; m0_cyc_i = 0;
        tick();
        m0_cyc_i = 1;
        tick();
        checks++;
        if (gnt_o !== 2'b10) begin errors++; $display("FAIL contend_alternate: gnt=%b want 10", gnt_o); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_lock;
        m1_cyc_i = 1;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int beat = 0; beat < 3; beat++) begin
            m1_stb_i = 1; m1_adr_i = 32'h2000 + beat; ack_i = 1;
            tick();
            m1_stb_i = 0; ack_i = 0;
            #1;
            checks++;
            if (gnt_o !== 2'b10 || m0_ack_o !== 1'b0) begin
                errors++; $display("FAIL lock_beat%0d: gnt=%b m0_ack=%b want 10 0", beat, gnt_o, m0_ack_o);
            end
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_watchdog;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        tick();
        tick();
        checks++;
        if (m0_err_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL wdog_early: err=%b to=%b want 0 0", m0_err_o, timeout_o);
        end
        tick();
        checks++;
        if (m0_err_o !== 1'b1 || timeout_o !== 1'b1 || m1_err_o !== 1'b0) begin
            errors++; $display("FAIL wdog_fire: err=%b to=%b m1err=%b want 1 1 0", m0_err_o, timeout_o, m1_err_o);
        end
        tick();
        ack_i = 1;
        #1;
        checks++;
        if ({cyc_o, stb_o, timeout_o, m0_err_o, m0_ack_o} !== 5'b0) begin
            errors++; $display("FAIL wdog_abort: cyc/stb/to/err/ack=%b want 00000", {cyc_o, stb_o, timeout_o, m0_err_o, m0_ack_o});
        end
        ack_i = 0;
        tick();
        tick();
        checks++;
        if (cyc_o !== 1'b0) begin errors++; $display("FAIL wdog_hold: cyc=%b want 0", cyc_o); end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        checks++;
        if (gnt_o !== 2'b01 || cyc_o !== 1'b1) begin
            errors++; $display("FAIL wdog_recover: gnt=%b cyc=%b want 01 1", gnt_o, cyc_o);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_ack_vs_fire;
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        tick();
        tick();
        tick();
        ack_i = 1;
        #1;
        checks++;
        if ({m1_ack_o, m1_err_o, timeout_o} !== 3'b100) begin
            errors++; $display("FAIL ack_wins: ack/err/to=%b want 100", {m1_ack_o, m1_err_o, timeout_o});
        end
        tick();
        ack_i = 0;
        #1;
        checks++;
        if (cyc_o !== 1'b1 || gnt_o !== 2'b10) begin
            errors++; $display("FAIL ack_wins_keep: cyc=%b gnt=%b want 1 10", cyc_o, gnt_o);
        end
    endtask

    task automatic test_mid_reset;
        ack_i = 1;
        rst = 1;
        tick();
        checks++;
        if ({gnt_o, cyc_o, stb_o, m0_ack_o, m1_ack_o} !== 6'b0) begin
            errors++; $display("FAIL mid_reset: gnt/cyc/stb/acks=%b want 000000", {gnt_o, cyc_o, stb_o, m0_ack_o, m1_ack_o});
        end
        rst = 0;
        clear_inputs();
        tick();
    endtask

    // Reference model: owner (0 none, 1 m0, 2 m1), aborted flag, last owner,
    // and the run length of unanswered strobes.
    task automatic test_random;
        int owner, last_m, unans, m;
        bit aborted, granted, fire, term;
        bit [1:0] cyc, stb;
        logic [70:0] exp_bus, got_bus;
        logic [6:0]  exp_t, got_t;
        logic [1:0]  exp_g;
        logic [31:0] adr [2];
        logic [31:0] wdat [2];
        logic [3:0]  sel [2];
        bit   [1:0]  we;
        do_reset();
        owner = 0; last_m = 0; unans = 0; aborted = 0; cyc = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 7) == 0) cyc[i] = ~cyc[i];
                stb[i] = cyc[i] & $urandom_range(0, 1);
                we[i] = $urandom_range(0, 1);
                adr[i] = $urandom; wdat[i] = $urandom; sel[i] = 4'($urandom);
            end
            m0_cyc_i = cyc[0]; m0_stb_i = stb[0]; m0_we_i = we[0]; m0_adr_i = adr[0]; m0_dat_i = wdat[0]; m0_sel_i = sel[0];
            m1_cyc_i = cyc[1]; m1_stb_i = stb[1]; m1_we_i = we[1]; m1_adr_i = adr[1]; m1_dat_i = wdat[1]; m1_sel_i = sel[1];
            dat_i = $urandom;
            ack_i = ($urandom_range(0, 5) == 0);
            err_i = ($urandom_range(0, 19) == 0);
            rty_i = ($urandom_range(0, 19) == 0);
            #1;
            granted = (owner != 0) && !aborted;
            m = (owner == 2) ? 1 : 0;
            term = ack_i | err_i | rty_i;
            exp_bus = '0; exp_t = '0; exp_g = 2'b00; fire = 0;
            if (granted) begin
                exp_bus = {cyc[m], stb[m], we[m], sel[m], adr[m], wdat[m]};
                exp_g = (m == 1) ? 2'b10 : 2'b01;
                fire = stb[m] && !term && (unans == TO - 1);
                if (m == 0) exp_t[6:4] = {stb[0] & ack_i, (stb[0] & err_i) | fire, stb[0] & rty_i};
                else        exp_t[3:1] = {stb[1] & ack_i, (stb[1] & err_i) | fire, stb[1] & rty_i};
                exp_t[0] = fire;
            end
            got_bus = {cyc_o, stb_o, we_o, sel_o, adr_o, dat_o};
            got_t = {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o, timeout_o};
            checks++;
            if (got_bus !== exp_bus) begin
                errors++; $display("FAIL rand_bus c=%0d: got %h want %h", c, got_bus, exp_bus);
            end
            checks++;
            if (got_t !== exp_t || gnt_o !== exp_g || m0_dat_o !== dat_i || m1_dat_o !== dat_i) begin
                errors++; $display("FAIL rand_resp c=%0d: terms=%b gnt=%b want terms=%b gnt=%b", c, got_t, gnt_o, exp_t, exp_g);
            end
            if (owner == 0) begin
                if (cyc[0] && cyc[1]) owner = (last_m == 0) ? 2 : 1;
                else if (cyc[1])      owner = 2;
                else if (cyc[0])      owner = 1;
                unans = 0;
            end else if (aborted) begin
                if (!cyc[m]) begin owner = 0; aborted = 0; last_m = m; end
            end else if (fire) begin
                aborted = 1; unans = 0;
            end else if (!cyc[m]) begin
                owner = 0; last_m = m; unans = 0;
            end else begin
                unans = (stb[m] && !term) ? unans + 1 : 0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_m0();
        test_contention();
        test_lock();
        test_watchdog();
        test_ack_vs_fire();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
